// File: rtl/quad_pkg.sv
// Shared types and step classification for the steering quadrature receiver.
package quad_pkg;

  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  typedef struct packed {
    logic legal;
    logic dir;
    logic moved;
  } quad_step_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  // Gray state to its position in the CW cycle 00->01->11->10
  function automatic logic [1:0] quad_phase(input quad_t q);
    logic [1:0] b;
    b = q;
    return {b[1], b[1] ^ b[0]};
  endfunction

  function automatic quad_step_t quad_step(input quad_t prev, input quad_t next);
    logic [1:0] delta;
    quad_step_t r;
    delta   = quad_phase(next) - quad_phase(prev);
    r.moved = (delta != 2'd0);
    r.legal = (delta == 2'd1) || (delta == 2'd3);
    r.dir   = (delta == 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/steer_quad_decoder_if.sv
// Bus between the quadrature source / CPU side and the steering decoder.
interface steer_quad_decoder_if #(
  parameter int POS_W = 8
);
  logic             Quad_A_I;
  logic             Quad_B_I;
  logic             Clr_I;
  logic [POS_W-1:0] Pos_O;
  logic             Dir_O;
  logic             Step_O;
  logic             Flag_O;
  logic             Err_O;
  logic [7:0]       Err_Cnt_O;

  modport master (
    output Quad_A_I, Quad_B_I, Clr_I,
    input  Pos_O, Dir_O, Step_O, Flag_O, Err_O, Err_Cnt_O
  );

  modport slave (
    input  Quad_A_I, Quad_B_I, Clr_I,
    output Pos_O, Dir_O, Step_O, Flag_O, Err_O, Err_Cnt_O
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// Synchroniser plus joint A/B stability filter; commit_o pulses in the cycle
// filt_o takes a new accepted pair.
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       Clk12,
  input  logic       Reset_n,
  input  logic       Quad_A_I,
  input  logic       Quad_B_I,
  output logic [1:0] filt_o,
  output logic       commit_o
);

  localparam int               CNT_W   = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             s;
  logic [1:0]             cand_q, cand_d;
  logic [1:0]             filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   commit_q, commit_d;

  assign s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

  // The count is judged on its post-edge value, so a pair seen on exactly
  // FILT_CYCLES consecutive samples is accepted on the last of them.
  always_comb begin
    cand_d = s;
    cnt_d  = cnt_q;
    if (s != cand_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    commit_d = (cnt_d == CNT_HIT) && (s != filt_q);
    filt_d   = commit_d ? s : filt_q;
  end

  always_ff @(posedge Clk12 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], Quad_A_I};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], Quad_B_I};
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      commit_q <= commit_d;
    end
  end

  assign filt_o   = filt_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/steer_quad_decoder.sv
// Steering quadrature receiver: filters A/B, decodes Gray steps into a signed
// position count, and keeps the CPU-visible moved flag and error counter.
module steer_quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int POS_W       = 8,
  parameter int X4_MODE     = 1
) (
  input  logic               Clk12,
  input  logic               Reset_n,
  steer_quad_decoder_if.slave quad_io
);

  logic       [1:0] filt;
  logic             commit;
  quad_t            filt_state;
  quad_step_t       st;
  logic             counted;

  quad_t            last_q, last_d;
  logic             init_q, init_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  quad_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .Clk12   (Clk12),
    .Reset_n (Reset_n),
    .Quad_A_I(quad_io.Quad_A_I),
    .Quad_B_I(quad_io.Quad_B_I),
    .filt_o  (filt),
    .commit_o(commit)
  );

  assign filt_state = quad_t'(filt);

  always_comb begin
    last_d    = last_q;
    init_d    = init_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    flag_d    = flag_q & ~quad_io.Clr_I;
    counted   = 1'b0;
    st        = quad_step(last_q, filt_state);
    if (commit) begin
      // The first accepted pair after reset only establishes the reference.
      last_d = filt_state;
      init_d = 1'b1;
      if (init_q) begin
        if (st.moved && !st.legal) begin
          err_d = 1'b1;
          if (err_cnt_q != ERR_SAT) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (st.legal) begin
          counted = (X4_MODE != 0) || (filt_state == Q00);
          if (counted) begin
            pos_d  = st.dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            dir_d  = st.dir;
            step_d = 1'b1;
            flag_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk12 or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q    <= Q00;
      init_q    <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      flag_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      last_q    <= last_d;
      init_q    <= init_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      flag_q    <= flag_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign quad_io.Pos_O     = pos_q;
  assign quad_io.Dir_O     = dir_q;
  assign quad_io.Step_O    = step_q;
  assign quad_io.Flag_O    = flag_q;
  assign quad_io.Err_O     = err_q;
  assign quad_io.Err_Cnt_O = err_cnt_q;

endmodule

// File: tb/tb_steer_quad_decoder.sv
// Drives one A/B stream into an x4 and an x1 decoder; expected step/error
// events are queued at stimulus time and matched by a monitor.
module tb_steer_quad_decoder;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] pos;
    logic       dir;
    logic [7:0] ecnt;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ab    = 2'b11;
  logic       clr   = 1'b0;
  int         cyc     = 0;
  int         n_total = 0;
  int         n_pass  = 0;

  ev_t        q4[$];
  ev_t        q1[$];
  logic       m_init = 1'b0;
  logic [1:0] m_last = 2'b00;
  logic [7:0] p4 = 8'd0;
  logic [7:0] p1 = 8'd0;
  logic [7:0] ecnt = 8'd0;
  logic       d4 = 1'b0;
  logic       d1 = 1'b0;

  steer_quad_decoder_if #(.POS_W(8)) if4 ();
  steer_quad_decoder_if #(.POS_W(8)) if1 ();

  assign if4.Quad_A_I = ab[1];
  assign if4.Quad_B_I = ab[0];
  assign if4.Clr_I    = clr;
  assign if1.Quad_A_I = ab[1];
  assign if1.Quad_B_I = ab[0];
  assign if1.Clr_I    = clr;

  steer_quad_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .POS_W(8), .X4_MODE(1)) dut4 (
    .Clk12(clk), .Reset_n(rst_n), .quad_io(if4)
  );
  steer_quad_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .POS_W(8), .X4_MODE(0)) dut1 (
    .Clk12(clk), .Reset_n(rst_n), .quad_io(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic logic [1:0] cw_next(input logic [1:0] x);
    case (x)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model of one accepted edge; t is the cycle the event must appear.
  task automatic model_edge(input logic [1:0] nab, input int t);
    ev_t e;
    bit  cw;
    if (!m_init) begin
      m_init = 1'b1;
      m_last = nab;
      return;
    end
    if (nab == m_last) return;
    if (nab == cw_next(m_last) || m_last == cw_next(nab)) begin
      cw = (nab == cw_next(m_last));
      p4 = cw ? p4 + 8'd1 : p4 - 8'd1;
      d4 = cw;
      e.cyc = t; e.err = 1'b0; e.pos = p4; e.dir = d4; e.ecnt = ecnt;
      q4.push_back(e);
      if (nab == 2'b00) begin
        p1 = cw ? p1 + 8'd1 : p1 - 8'd1;
        d1 = cw;
        e.pos = p1; e.dir = d1;
        q1.push_back(e);
      end
    end else begin
      if (ecnt != 8'hFF) ecnt = ecnt + 8'd1;
      e.cyc = t; e.err = 1'b1; e.pos = p4; e.dir = d4; e.ecnt = ecnt;
      q4.push_back(e);
      e.pos = p1; e.dir = d1;
      q1.push_back(e);
    end
    m_last = nab;
  endtask

  task automatic mon(input bit x1, input logic step, input logic err,
                     input logic [7:0] pos, input logic dir, input logic [7:0] ec);
    ev_t   e;
    string nm;
    nm = x1 ? "x1" : "x4";
    if ((x1 && q1.size() == 0) || (!x1 && q4.size() == 0)) begin
      check($sformatf("%s queued event at cycle %0d", nm, cyc), 0, 1);
      return;
    end
    if (x1) e = q1.pop_front();
    else    e = q4.pop_front();
    check({nm, " event kind (2=step 1=err)"}, int'({step, err}), e.err ? 1 : 2);
    check({nm, " event cycle"}, cyc, e.cyc);
    check({nm, " Pos_O"}, int'(pos), int'(e.pos));
    check({nm, " Dir_O"}, int'(dir), int'(e.dir));
    check({nm, " Err_Cnt_O"}, int'(ec), int'(e.ecnt));
  endtask

  always @(negedge clk) begin
    if (rst_n && (if4.Step_O || if4.Err_O))
      mon(1'b0, if4.Step_O, if4.Err_O, if4.Pos_O, if4.Dir_O, if4.Err_Cnt_O);
    if (rst_n && (if1.Step_O || if1.Err_O))
      mon(1'b1, if1.Step_O, if1.Err_O, if1.Pos_O, if1.Dir_O, if1.Err_Cnt_O);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] nab);
    @(negedge clk);
    ab = nab;
    model_edge(nab, cyc + 7);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("x4 reset Pos_O", int'(if4.Pos_O), 0);
    check("x4 reset Dir_O", int'(if4.Dir_O), 0);
    check("x4 reset Step_O", int'(if4.Step_O), 0);
    check("x4 reset Flag_O", int'(if4.Flag_O), 0);
    check("x4 reset Err_O", int'(if4.Err_O), 0);
    check("x4 reset Err_Cnt_O", int'(if4.Err_Cnt_O), 0);
    check("x1 reset Pos_O", int'(if1.Pos_O), 0);
    check("x1 reset Flag_O", int'(if1.Flag_O), 0);
    m_init = 1'b0; m_last = 2'b00;
    p4 = 8'd0; p1 = 8'd0; d4 = 1'b0; d1 = 1'b0; ecnt = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_edge(ab, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not reach the end, got time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    // 1: power-up with AB=11 held: first commit only initialises
    do_reset();
    idle(15);
    check("init Pos_O", int'(if4.Pos_O), 0);

    // 2: four CW steps from 11
    drive(2'b10); idle(19);
    drive(2'b00); idle(19);
    drive(2'b01); idle(19);
    drive(2'b11); idle(19);
    check("4xCW Pos_O", int'(if4.Pos_O), 4);
    check("4xCW Dir_O", int'(if4.Dir_O), 1);
    check("4xCW Flag_O", int'(if4.Flag_O), 1);
    check("x1 4xCW Pos_O", int'(if1.Pos_O), 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("Clr Flag_O", int'(if4.Flag_O), 0);

    // 3: underflow wrap, then x1 counting only into 00
    do_reset();
    idle(15);
    drive(2'b01); idle(19);
    check("CCW wrap Pos_O", int'(if4.Pos_O), 8'hFF);
    check("CCW wrap Dir_O", int'(if4.Dir_O), 0);
    drive(2'b00); idle(19);
    drive(2'b10); idle(19);
    drive(2'b11); idle(19);
    drive(2'b01); idle(19);
    check("x1 4xCCW Pos_O", int'(if1.Pos_O), 8'hFF);
    check("x1 4xCCW Dir_O", int'(if1.Dir_O), 0);
    check("x4 5xCCW Pos_O", int'(if4.Pos_O), 8'hFB);

    // 4: 3-cycle glitch rejected, 4-cycle pulse accepted both ways
    @(negedge clk); ab = 2'b11;
    idle(3); ab = 2'b01;
    idle(20);
    check("3-cycle glitch Pos_O", int'(if4.Pos_O), 8'hFB);
    drive(2'b11); idle(3);
    drive(2'b01); idle(20);
    check("4-cycle pulse Pos_O", int'(if4.Pos_O), 8'hFB);
    check("4-cycle pulse Dir_O", int'(if4.Dir_O), 0);

    // 5: illegal jump, recovery, saturation
    drive(2'b00); idle(19);
    drive(2'b11); idle(19);
    check("jump Err_Cnt_O", int'(if4.Err_Cnt_O), 1);
    check("jump Pos_O", int'(if4.Pos_O), 8'hFA);
    drive(2'b10); idle(19);
    check("after jump Pos_O", int'(if4.Pos_O), 8'hFB);
    check("after jump Dir_O", int'(if4.Dir_O), 1);
    for (int i = 0; i < 300; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10);
      idle(5);
    end
    idle(20);
    check("x4 saturated Err_Cnt_O", int'(if4.Err_Cnt_O), 255);
    check("x1 saturated Err_Cnt_O", int'(if1.Err_Cnt_O), 255);

    // 6: clear coinciding with a step, then reset mid-filter
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("pre-race Flag_O", int'(if4.Flag_O), 0);
    drive(2'b00);
    idle(6); clr = 1'b1;
    idle(1); clr = 1'b0;
    check("x4 set beats clear Flag_O", int'(if4.Flag_O), 1);
    check("x1 set beats clear Flag_O", int'(if1.Flag_O), 1);
    idle(15);
    @(negedge clk); ab = 2'b01;
    idle(3);
    do_reset();
    idle(20);
    drive(2'b11); idle(19);
    check("post-reset Pos_O", int'(if4.Pos_O), 1);
    check("post-reset Dir_O", int'(if4.Dir_O), 1);
    check("x1 post-reset Pos_O", int'(if1.Pos_O), 0);

    check("x4 missing events", q4.size(), 0);
    check("x1 missing events", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
